// File: rtl/pll_dco_loop_if.sv
// Loop control inputs (enable, PFD pulses) and DCO/lock status outputs.
// The link controller drives master; the loop itself is the slave.
interface pll_dco_loop_if #(
  parameter int ACC_W = 16
);
  logic             en;
  logic             up;
  logic             dn;
  logic [ACC_W-1:0] fcw;
  logic             clk_out;
  logic             tick;
  logic             locked;

  modport master (output en, up, dn, input fcw, clk_out, tick, locked);
  modport slave  (input en, up, dn, output fcw, clk_out, tick, locked);
endinterface

// File: rtl/pll_dco_loop.sv
// PI loop filter steering a phase-accumulator DCO, plus a lock detector.
// PFD edge -> fcw change takes 4 cycles; no backpressure (free-running loop).
module pll_dco_loop #(
  parameter int               ACC_W    = 16,
  parameter logic [ACC_W-1:0] FCW_NOM  = 16'h1000,
  parameter logic [ACC_W-1:0] FCW_MIN  = 16'h0800,
  parameter logic [ACC_W-1:0] FCW_MAX  = 16'h2000,
  parameter int               KP_SHIFT = 4,
  parameter int               KI_SHIFT = 0,
  parameter int               INT_W    = 13,
  parameter int               LOCK_CYC = 64
) (
  input  logic           clk,
  input  logic           rst,
  pll_dco_loop_if.slave  bus
);

  localparam int FW = ACC_W + 2;
  localparam int IW = INT_W + KI_SHIFT + 2;
  localparam int CW = $clog2(LOCK_CYC + 1);

  localparam logic signed [IW-1:0] IMAX = IW'((1 <<< (INT_W - 1)) - 1);
  localparam logic signed [IW-1:0] IMIN = -IMAX;
  localparam logic signed [FW-1:0] FMIN = {2'b00, FCW_MIN};
  localparam logic signed [FW-1:0] FMAX = {2'b00, FCW_MAX};

  logic [2:0]             up_sync, dn_sync;
  logic                   up_evt, dn_evt;
  logic signed [1:0]      err;
  logic [INT_W-1:0]       integ, integ_next;
  logic signed [IW-1:0]   integ_sum;
  logic signed [FW-1:0]   fcw_sum;
  logic [ACC_W-1:0]       fcw_q, fcw_next;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W:0]         acc_sum;
  logic [CW-1:0]          lock_cnt, lock_cnt_next;
  logic                   clk_out_q, tick_q, locked_q;

  // Simultaneous up/dn edges cancel; events outside en are dropped.
  always_comb begin
    err = 2'sb00;
    if (bus.en && up_evt && !dn_evt)
      err = 2'sb01;
    else if (bus.en && dn_evt && !up_evt)
      err = 2'sb11;
  end

  always_comb begin
    integ_sum = {{(IW-INT_W){integ[INT_W-1]}}, integ}
              + ({{(IW-2){err[1]}}, err} <<< KI_SHIFT);
    if (integ_sum > IMAX)
      integ_next = IMAX[INT_W-1:0];
    else if (integ_sum < IMIN)
      integ_next = IMIN[INT_W-1:0];
    else
      integ_next = integ_sum[INT_W-1:0];
  end

  // Widened sum so a saturated integrator plus the kick cannot wrap before the clamp.
  always_comb begin
    fcw_sum = {2'b00, FCW_NOM}
            + {{(FW-INT_W){integ_next[INT_W-1]}}, integ_next}
            + ({{(FW-2){err[1]}}, err} <<< KP_SHIFT);
    if (fcw_sum < FMIN)
      fcw_next = FCW_MIN;
    else if (fcw_sum > FMAX)
      fcw_next = FCW_MAX;
    else
      fcw_next = fcw_sum[ACC_W-1:0];
  end

  always_comb begin
    acc_sum = {1'b0, acc} + {1'b0, fcw_q};
    if (!bus.en || err != 2'sb00)
      lock_cnt_next = '0;
    else if (lock_cnt == CW'(LOCK_CYC))
      lock_cnt_next = lock_cnt;
    else
      lock_cnt_next = lock_cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_sync   <= '0;
      dn_sync   <= '0;
      up_evt    <= 1'b0;
      dn_evt    <= 1'b0;
      integ     <= '0;
      fcw_q     <= FCW_NOM;
      acc       <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      lock_cnt  <= '0;
      locked_q  <= 1'b0;
    end else begin
      up_sync  <= {up_sync[1:0], bus.up};
      dn_sync  <= {dn_sync[1:0], bus.dn};
      up_evt   <= up_sync[1] & ~up_sync[2];
      dn_evt   <= dn_sync[1] & ~dn_sync[2];
      lock_cnt <= lock_cnt_next;
      locked_q <= (lock_cnt_next == CW'(LOCK_CYC));
      if (bus.en) begin
        integ     <= integ_next;
        fcw_q     <= fcw_next;
        acc       <= acc_sum[ACC_W-1:0];
        tick_q    <= acc_sum[ACC_W];
        clk_out_q <= acc_sum[ACC_W-1];
      end else begin
        tick_q    <= 1'b0;
      end
    end
  end

  assign bus.fcw     = fcw_q;
  assign bus.clk_out = clk_out_q;
  assign bus.tick    = tick_q;
  assign bus.locked  = locked_q;

endmodule

// File: tb/tb_pll_dco_loop.sv
// Directed bench for pll_dco_loop: reset, free-run DCO, PI kicks, cancel,
// enable gating, mid-run reset and integrator/fcw saturation.
module tb_pll_dco_loop;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  pll_dco_loop_if #(.ACC_W(16)) bus ();

  pll_dco_loop dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 2-cycle-wide PFD pulse followed by 6 quiet cycles.
  task automatic pulse(input bit is_up);
    if (is_up) bus.up = 1'b1;
    else       bus.dn = 1'b1;
    step(2);
    bus.up = 1'b0;
    bus.dn = 1'b0;
    step(6);
  endtask

  function automatic logic [31:0] exp_fcw(input int v);
    if (v < 'h800)  return 32'h800;
    if (v > 'h2000) return 32'h2000;
    return 32'(v);
  endfunction

  initial begin
    rst    = 1'b1;
    bus.en = 1'b0;
    bus.up = 1'b0;
    bus.dn = 1'b0;
    #2;
    chk("rst_fcw",     bus.fcw,     32'h1000);
    chk("rst_clk_out", bus.clk_out, 0);
    chk("rst_tick",    bus.tick,    0);
    chk("rst_locked",  bus.locked,  0);

    // Free run at nominal: tick every 16, clk_out 8 high / 8 low, lock after 64.
    step(1);
    rst    = 1'b0;
    bus.en = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      step(1);
      chk("run_tick",    bus.tick,    32'((k % 16) == 0));
      chk("run_clk_out", bus.clk_out, 32'((k % 16) >= 8));
      chk("run_locked",  bus.locked,  32'(k >= 64));
    end
    chk("run_fcw", bus.fcw, 32'h1000);

    // Single up pulse: kick 0x1011 for one cycle, then integ=1 -> 0x1001.
    bus.up = 1'b1;
    step(2);
    bus.up = 1'b0;
    step(1);
    chk("up_pre_fcw",    bus.fcw,    32'h1000);
    chk("up_pre_locked", bus.locked, 1);
    step(1);
    chk("up_kick_fcw",   bus.fcw,    32'h1011);
    chk("up_kick_locked", bus.locked, 0);
    step(1);
    chk("up_steady_fcw", bus.fcw,    32'h1001);
    step(62);
    chk("relock_early",  bus.locked, 0);
    step(1);
    chk("relock",        bus.locked, 1);

    // Coincident up and dn edges cancel.
    bus.up = 1'b1;
    bus.dn = 1'b1;
    step(2);
    bus.up = 1'b0;
    bus.dn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("both_fcw",    bus.fcw,    32'h1001);
      chk("both_locked", bus.locked, 1);
    end

    // en=0 for 20 cycles with 3 up pulses: frozen, discarded.
    bus.en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c < 15 && (c % 5) == 0) bus.up = 1'b1;
      if ((c % 5) == 2)           bus.up = 1'b0;
      step(1);
      chk("dis_fcw",    bus.fcw,    32'h1001);
      chk("dis_tick",   bus.tick,   0);
      chk("dis_locked", bus.locked, 0);
    end
    bus.en = 1'b1;
    step(6);
    chk("reen_fcw",    bus.fcw,    32'h1001);
    chk("reen_locked", bus.locked, 0);

    // Drive integ to +100, then asynchronous reset mid-run.
    repeat (99) pulse(1'b1);
    chk("integ100_fcw", bus.fcw, 32'h1064);
    rst = 1'b1;
    #1;
    chk("mid_rst_fcw",     bus.fcw,     32'h1000);
    chk("mid_rst_clk_out", bus.clk_out, 0);
    chk("mid_rst_tick",    bus.tick,    0);
    chk("mid_rst_locked",  bus.locked,  0);
    step(1);
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step(1);
      chk("post_rst_tick",    bus.tick,    32'((k % 16) == 0));
      chk("post_rst_clk_out", bus.clk_out, 32'((k % 16) >= 8));
    end
    chk("post_rst_fcw", bus.fcw, 32'h1000);

    // 5000 dn pulses: integ saturates at -4095, fcw pinned at FCW_MIN.
    for (int n = 1; n <= 5000; n++) begin
      pulse(1'b0);
      if (n <= 2 || n == 2047 || n == 2048 || n == 2049 || n == 4095 || n == 5000)
        chk("sat_dn_fcw", bus.fcw, exp_fcw(4096 + ((n > 4095) ? -4095 : -n)));
    end

    // One up: 0x1000-4094+16 still below the clamp, in kick and steady cycles.
    bus.up = 1'b1;
    step(2);
    bus.up = 1'b0;
    step(2);
    chk("sat_up_kick_fcw",   bus.fcw, 32'h800);
    step(4);
    chk("sat_up_steady_fcw", bus.fcw, 32'h800);

    // Climb from -4094: the 2048th up leaves clamp only if integ stopped at -4095.
    for (int m = 2; m <= 2048; m++) begin
      pulse(1'b1);
      if (m == 2047 || m == 2048)
        chk("climb_fcw", bus.fcw, exp_fcw(1 + m));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_dco_loop.md
Name: pll_dco_loop

Overview:
- Digital loop-filter plus numerically controlled oscillator. It closes the PLL around the phase/frequency detector.
- Consumes the detector's UP/DN pulses and runs them through a proportional-integral filter. The filter output steers a phase-accumulator DCO that generates the recovered/feedback clock for the SERDES.
- Includes a lock detector that reports loop settling to the link controller.

Parameters:
- ACC_W, 16, phase accumulator and FCW width in bits
- FCW_NOM, 16'h1000, nominal frequency control word loaded at reset
- FCW_MIN, 16'h0800, lower clamp on effective FCW
- FCW_MAX, 16'h2000, upper clamp on effective FCW
- KP_SHIFT, 4, proportional gain exponent (prop = e * 2^KP_SHIFT)
- KI_SHIFT, 0, integral gain exponent (integrator step = e * 2^KI_SHIFT)
- INT_W, 13, signed integrator width
- LOCK_CYC, 64, consecutive error-free enabled cycles required to declare lock

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  loop/oscillator enable
- up  in  1  PFD UP output, asynchronous to clk
- dn  in  1  PFD DN output, asynchronous to clk
- fcw  out  ACC_W  registered effective frequency control word
- clk_out  out  1  DCO output, registered accumulator MSB
- tick  out  1  one-cycle pulse on accumulator wrap (carry out)
- locked  out  1  lock indicator

Behaviour:
- Reset (async, immediate):
  - Sync/edge flops, accumulator, integrator, lock counter, clk_out, tick and locked all go to 0.
  - fcw goes to FCW_NOM.
- Input synchronisation:
  - up and dn each pass through 2 flops, then a rising-edge detect (third flop).
  - Each edge yields a 1-cycle up_evt/dn_evt. A held-high level counts once.
- Error term e:
  - +1 if up_evt only; -1 if dn_evt only.
  - 0 if neither, or both in the same cycle.
- Integrator (only when en=1):
  - integ <= sat(integ + e*2^KI_SHIFT), saturating at +/-(2^(INT_W-1)-1).
  - No wrap.
- FCW:
  - fcw <= clamp(FCW_NOM + integ_next + e*2^KP_SHIFT, FCW_MIN, FCW_MAX).
  - Computed sign-extended to ACC_W+2 bits before the clamp.
  - Proportional kick applies only in the event cycle.
  - Latency: input edge -> fcw change = 4 clk cycles (2 sync, 1 edge, 1 register).
- Accumulator (when en=1):
  - acc <= acc + fcw, modulo 2^ACC_W.
  - tick <= carry out of that add.
  - clk_out <= MSB of the new acc value.
- en=0:
  - acc, integ and fcw hold; tick=0; clk_out holds.
  - Events are discarded; sync flops keep running.
  - Lock counter and locked clear.
- Lock detector:
  - Counter increments each enabled cycle with e=0, saturating at LOCK_CYC.
  - Counter clears on any cycle with e!=0. The both-edges case (e=0) does not clear it.
  - locked=1 while counter == LOCK_CYC. It drops the cycle after an error event.
- fcw clamp: applies even when FCW_NOM plus a saturated integ exceeds the bounds.
- Reset mid-operation: all state returns to reset values in the same cycle. Operation resumes from FCW_NOM with integ=0 on the first edge after release.

Test Plan:
- Reset release, en=1, no up/dn -> fcw=0x1000, tick every 16 cycles, clk_out period 16 cycles (8 high/8 low), locked rises 64 cycles after en.
- Single up pulse (2 cycles wide) after lock -> 4 cycles later fcw=0x1011 for one cycle, then 0x1001 steady; locked drops the next cycle and re-asserts after 64 quiet cycles.
- up and dn rising in the same clk cycle -> fcw unchanged at 0x1000, locked stays 1.
- 5000 dn pulses spaced 8 cycles apart -> integ saturates at -4095, fcw settles at the clamp 0x0800 and never wraps; then 1 up pulse -> fcw stays 0x0800 (0x1000-4094+16 still below min).
- Integ driven to +100, then rst pulsed for 1 cycle -> fcw=0x1000, acc=0, clk_out=0, locked=0 immediately; after release the tick period returns to 16.
- en=0 for 20 cycles with 3 up pulses -> acc and fcw frozen, tick=0, locked=0; after en=1, fcw unchanged and the pulses have no effect.
